rab_slice_lookup_pipe: RTL and testbench
========================================

Name: rab_slice_lookup_pipe

Overview:
- Pipelined, parametrised successor to the combinational slice lookup in the RAB.
- Matches an incoming AXI address range against N_SLICES configured slices and resolves hit, protection, multi-hit and translated physical address.
- Uses a 2-stage valid/ready pipeline carrying a transaction ID, with a selectable multi-hit policy and sticky error/statistics capture.
- Sits between the AXI address-channel front end and the RAB miss/forwarding logic.

Parameters:
N_SLICES, 16, number of translation slices (1..32)
N_REGS, 4*N_SLICES, number of 64-bit config registers (4 per slice)
ADDR_WIDTH_PHYS, 40, physical (output) address width
ADDR_WIDTH_VIRT, 32, virtual (input) address width
ID_WIDTH, 8, width of transaction ID carried alongside the request
MH_POLICY, 0, multi-hit policy: 0 = treat as error, no hit; 1 = lowest-index hitting slice wins
CNT_WIDTH, 16, width of saturating error counters

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous active-low reset
cfg_regs_i  in  N_REGS x 64  config: reg 4i = min, 4i+1 = max, 4i+2 = offset, 4i+3 = {..,master[3],wen[2],ren[1],en[0]}
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when valid & ready
in_rw_i  in  1  1 = write, 0 = read
in_addr_min_i  in  ADDR_WIDTH_VIRT  first byte address of burst
in_addr_max_i  in  ADDR_WIDTH_VIRT  last byte address of burst
in_id_i  in  ID_WIDTH  transaction ID
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when valid & ready
out_id_o  out  ID_WIDTH  ID of result
out_addr_o  out  ADDR_WIDTH_PHYS  translated address ('0 unless clean hit)
out_master_sel_o  out  1  master bit of selected slice ('0 unless clean hit)
out_hit_o  out  1  exactly one slice selected (per policy)
out_hit_idx_o  out  $clog2(N_SLICES)  selected slice index
out_multi_hit_o  out  1  more than one slice matched
out_prot_o  out  1  selected slice denies this access type
err_clr_i  in  1  clears sticky error capture and counters
err_valid_o  out  1  sticky: an error result has been consumed
err_addr_o  out  ADDR_WIDTH_VIRT  in_addr_min of first error result
err_id_o  out  ID_WIDTH  ID of first error result
miss_cnt_o  out  CNT_WIDTH  saturating count of miss results
mh_cnt_o  out  CNT_WIDTH  saturating count of multi-hit results
prot_cnt_o  out  CNT_WIDTH  saturating count of protection results

Behaviour:
- Reset:
  - All valid bits, err_valid_o and counters are 0; all data outputs are '0.
  - in_ready_o = 1 once reset is released.
- Slice match (stage 1, on acceptance):
  - match[i] = en & (in_addr_min >= min[VIRT-1:0]) & (in_addr_max <= max[VIRT-1:0]); all comparisons unsigned.
  - Per-slice address = offset[PHYS-1:0] + zero_ext(in_addr_min - min), truncated to ADDR_WIDTH_PHYS (modulo wrap).
  - The stage-1 register stores match vector, per-slice rw-permission bits, master bits, per-slice addresses, rw, addr_min and id.
  - Config changes after acceptance do not affect that transaction.
- Resolve (stage 2):
  - popcount(match) == 0: miss; hit = 0, prot = 0, multi = 0.
  - popcount(match) == 1: hit = 1, idx = that slice.
  - popcount(match) >= 2: multi = 1.
    - MH_POLICY = 0: hit = 0, addr = '0, master = 0, idx = 0.
    - MH_POLICY = 1: hit = 1, idx = lowest matching index.
  - When hit = 1: prot = (rw & ~wen[idx]) | (~rw & ~ren[idx]); if prot = 1, addr = '0 and master = 0.
- Pipeline and handshake:
  - Latency is 2 cycles from acceptance to out_valid_o; full throughput of 1 per cycle.
  - s2_ready = ~s2_valid | out_ready_i; in_ready_o = ~s1_valid | s2_ready.
  - Outputs are registered and held stable while out_valid_o & ~out_ready_i; no bubbles under continuous ready.
- Error result:
  - An error result is a miss, a multi-hit or a protection fault.
  - Counters increment only on output handshake and saturate at all-ones.
  - A multi-hit with MH_POLICY = 1 counts in mh_cnt_o but is an error only if a protection fault also occurs.
- Sticky capture:
  - The first error handshake with err_valid_o = 0 latches err_addr_o/err_id_o and sets err_valid_o.
  - err_clr_i takes effect on the next edge: it clears counters and err_valid_o.
  - If err_clr_i and an error handshake occur in the same cycle, the new error is captured and counters restart at 1 for its class.
- Asynchronous reset mid-operation discards in-flight requests with no output handshake.

Decomposition:
- Package rab_lookup_pkg:
  - cfg field offsets (REG_MIN = 0, REG_MAX = 1, REG_OFFS = 2, REG_FLAGS = 3; flag bit positions EN = 0, REN = 1, WEN = 2, MASTER = 3).
  - MH_POLICY enum.
  - Packed stage-1 struct typedef.
- One sub-module, rab_slice_match: a single slice's combinational compare, permission and address computation, instantiated N_SLICES times in a generate loop.

Test Plan:
- Slice 2 {min = 0x1000, max = 0x1FFF, offs = 0x80_0000_0000, en, ren}, read 0x1100..0x113F, id = 5 -> after 2 cycles: out_hit = 1, idx = 2, addr = 0x80_0000_0100, prot = 0, id = 5.
- Same slice, write -> hit = 1, prot = 1, addr = 0; prot_cnt = 1; err_valid = 1 with err_addr = 0x1100.
- Slices 1 and 3 overlap 0x2000..0x2FFF, read 0x2010:
  - MH_POLICY = 0 -> hit = 0, multi = 1, mh_cnt = 1.
  - MH_POLICY = 1 -> hit = 1, idx = 1, multi = 1.
- Burst 0x1FF0..0x200F straddling slice end -> miss, miss_cnt = 1; then 0xFFFF+1 further misses -> miss_cnt saturates at 0xFFFF.
- Back-to-back 4 requests with out_ready low for 3 cycles -> in_ready drops after 2 accepted; outputs held stable; all 4 delivered in order with correct ids.
- err_clr_i asserted in the same cycle as a miss handshake (id = 9) -> err_valid = 1, err_id = 9, miss_cnt = 1; reset asserted with 2 in flight -> out_valid = 0 and no output handshake.

Source files
------------

// File: rtl/rab_lookup_pkg.sv
// Shared definitions for the pipelined RAB slice lookup: config register layout,
// multi-hit policy encoding and the per-slice result carried in stage 1.
package rab_lookup_pkg;

  localparam int REG_MIN   = 0;
  localparam int REG_MAX   = 1;
  localparam int REG_OFFS  = 2;
  localparam int REG_FLAGS = 3;

  localparam int FLAG_EN     = 0;
  localparam int FLAG_REN    = 1;
  localparam int FLAG_WEN    = 2;
  localparam int FLAG_MASTER = 3;

  typedef enum logic {
    MH_ERROR  = 1'b0,
    MH_LOWEST = 1'b1
  } mh_policy_e;

  typedef struct packed {
    logic match;
    logic ren;
    logic wen;
    logic master;
  } slice_res_t;

endpackage

// File: rtl/rab_slice_match.sv
// One translation slice: range compare against the burst, permission flags and
// the candidate physical address for this slice.
module rab_slice_match
  import rab_lookup_pkg::*;
#(
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ADDR_WIDTH_VIRT = 32
) (
  input  logic [63:0]                cfg_min,
  input  logic [63:0]                cfg_max,
  input  logic [63:0]                cfg_offs,
  input  logic [63:0]                cfg_flags,
  input  logic [ADDR_WIDTH_VIRT-1:0] addr_min,
  input  logic [ADDR_WIDTH_VIRT-1:0] addr_max,
  output slice_res_t                 res,
  output logic [ADDR_WIDTH_PHYS-1:0] addr
);

  logic [ADDR_WIDTH_VIRT-1:0] lo;
  logic [ADDR_WIDTH_VIRT-1:0] hi;
  logic [ADDR_WIDTH_VIRT-1:0] delta;
  logic                       unused_cfg;

  assign lo    = cfg_min[ADDR_WIDTH_VIRT-1:0];
  assign hi    = cfg_max[ADDR_WIDTH_VIRT-1:0];
  assign delta = addr_min - lo;

  // The whole burst must lie inside the slice; a straddling burst is a miss.
  assign res.match  = cfg_flags[FLAG_EN] & (addr_min >= lo) & (addr_max <= hi);
  assign res.ren    = cfg_flags[FLAG_REN];
  assign res.wen    = cfg_flags[FLAG_WEN];
  assign res.master = cfg_flags[FLAG_MASTER];

  // Offset is added modulo 2^ADDR_WIDTH_PHYS.
  assign addr = cfg_offs[ADDR_WIDTH_PHYS-1:0] + ADDR_WIDTH_PHYS'(delta);

  assign unused_cfg = ^{cfg_min, cfg_max, cfg_offs, cfg_flags};

endmodule

// File: rtl/rab_slice_lookup_pipe.sv
// Two-stage valid/ready slice lookup: stage 1 captures all per-slice matches,
// stage 2 resolves hit/multi-hit/protection and feeds sticky error statistics.
module rab_slice_lookup_pipe
  import rab_lookup_pkg::*;
#(
  parameter int N_SLICES        = 16,
  parameter int N_REGS          = 4 * N_SLICES,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MH_POLICY       = 0,
  parameter int CNT_WIDTH       = 16,
  localparam int IDX_W          = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic [63:0]                cfg_regs_i [N_REGS],
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       in_rw_i,
  input  logic [ADDR_WIDTH_VIRT-1:0] in_addr_min_i,
  input  logic [ADDR_WIDTH_VIRT-1:0] in_addr_max_i,
  input  logic [ID_WIDTH-1:0]        in_id_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [ID_WIDTH-1:0]        out_id_o,
  output logic [ADDR_WIDTH_PHYS-1:0] out_addr_o,
  output logic                       out_master_sel_o,
  output logic                       out_hit_o,
  output logic [IDX_W-1:0]           out_hit_idx_o,
  output logic                       out_multi_hit_o,
  output logic                       out_prot_o,
  input  logic                       err_clr_i,
  output logic                       err_valid_o,
  output logic [ADDR_WIDTH_VIRT-1:0] err_addr_o,
  output logic [ID_WIDTH-1:0]        err_id_o,
  output logic [CNT_WIDTH-1:0]       miss_cnt_o,
  output logic [CNT_WIDTH-1:0]       mh_cnt_o,
  output logic [CNT_WIDTH-1:0]       prot_cnt_o
);

  localparam mh_policy_e POLICY = (MH_POLICY != 0) ? MH_LOWEST : MH_ERROR;

  slice_res_t                 cur_res  [N_SLICES];
  logic [ADDR_WIDTH_PHYS-1:0] cur_addr [N_SLICES];

  for (genvar g = 0; g < N_SLICES; g++) begin : g_slice
    rab_slice_match #(
      .ADDR_WIDTH_PHYS(ADDR_WIDTH_PHYS),
      .ADDR_WIDTH_VIRT(ADDR_WIDTH_VIRT)
    ) u_match (
      .cfg_min  (cfg_regs_i[4*g+REG_MIN]),
      .cfg_max  (cfg_regs_i[4*g+REG_MAX]),
      .cfg_offs (cfg_regs_i[4*g+REG_OFFS]),
      .cfg_flags(cfg_regs_i[4*g+REG_FLAGS]),
      .addr_min (in_addr_min_i),
      .addr_max (in_addr_max_i),
      .res      (cur_res[g]),
      .addr     (cur_addr[g])
    );
  end

  // Stage 1: snapshot of every slice result, so later config writes cannot
  // disturb a transaction already accepted.
  logic                       s1_valid;
  slice_res_t                 s1_res  [N_SLICES];
  logic [ADDR_WIDTH_PHYS-1:0] s1_addr [N_SLICES];
  logic                       s1_rw;
  logic [ADDR_WIDTH_VIRT-1:0] s1_addr_min;
  logic [ID_WIDTH-1:0]        s1_id;

  logic s2_ready;
  logic accept;

  assign s2_ready   = ~out_valid_o | out_ready_i;
  assign in_ready_o = ~s1_valid | s2_ready;
  assign accept     = in_valid_i & in_ready_o;

  // NOTE: clocked state is always written with <= so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_valid    <= 1'b0;
      s1_rw       <= 1'b0;
      s1_addr_min <= '0;
      s1_id       <= '0;
      for (int i = 0; i < N_SLICES; i++) begin
        s1_res[i]  <= '0;
        s1_addr[i] <= '0;
      end
    end else begin
      if (in_ready_o) s1_valid <= in_valid_i;
      if (accept) begin
        s1_rw       <= in_rw_i;
        s1_addr_min <= in_addr_min_i;
        s1_id       <= in_id_i;
        for (int i = 0; i < N_SLICES; i++) begin
          s1_res[i]  <= cur_res[i];
          s1_addr[i] <= cur_addr[i];
        end
      end
    end
  end

  logic                       any_match;
  logic                       multi;
  logic [IDX_W-1:0]           low_idx;
  slice_res_t                 sel;
  logic                       r_hit;
  logic                       r_prot;
  logic                       r_clean;
  logic [IDX_W-1:0]           r_idx;
  logic [ADDR_WIDTH_PHYS-1:0] r_addr;
  logic                       r_master;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    any_match = 1'b0;
    multi     = 1'b0;
    low_idx   = '0;
    for (int i = N_SLICES - 1; i >= 0; i--) begin
      if (s1_res[i].match) low_idx = IDX_W'(i);
    end
    for (int i = 0; i < N_SLICES; i++) begin
      if (s1_res[i].match) begin
        multi     = multi | any_match;
        any_match = 1'b1;
      end
    end
    sel      = s1_res[low_idx];
    r_hit    = any_match & (~multi | (POLICY == MH_LOWEST));
    r_idx    = r_hit ? low_idx : '0;
    r_prot   = r_hit & (s1_rw ? ~sel.wen : ~sel.ren);
    r_clean  = r_hit & ~r_prot;
    r_addr   = r_clean ? s1_addr[low_idx] : '0;
    r_master = r_clean & sel.master;
  end

  // Stage 2 output registers; held while the consumer stalls.
  logic [ADDR_WIDTH_VIRT-1:0] out_addr_min_q;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      out_valid_o      <= 1'b0;
      out_id_o         <= '0;
      out_addr_o       <= '0;
      out_master_sel_o <= 1'b0;
      out_hit_o        <= 1'b0;
      out_hit_idx_o    <= '0;
      out_multi_hit_o  <= 1'b0;
      out_prot_o       <= 1'b0;
      out_addr_min_q   <= '0;
    end else if (s2_ready) begin
      out_valid_o <= s1_valid;
      if (s1_valid) begin
        out_id_o         <= s1_id;
        out_addr_o       <= r_addr;
        out_master_sel_o <= r_master;
        out_hit_o        <= r_hit;
        out_hit_idx_o    <= r_idx;
        out_multi_hit_o  <= multi;
        out_prot_o       <= r_prot;
        out_addr_min_q   <= s1_addr_min;
      end
    end
  end

  logic out_hs;
  logic is_miss;
  logic is_err;

  assign out_hs  = out_valid_o & out_ready_i;
  assign is_miss = ~out_hit_o & ~out_multi_hit_o;
  assign is_err  = ~out_hit_o | out_prot_o;

  // A clear coinciding with an event restarts the counter at 1.
  function automatic logic [CNT_WIDTH-1:0] cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic ev, input logic clr);
    if (clr) return ev ? CNT_WIDTH'(1) : '0;
    if (ev && (cnt != '1)) return cnt + 1'b1;
    return cnt;
  endfunction

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      miss_cnt_o  <= '0;
      mh_cnt_o    <= '0;
      prot_cnt_o  <= '0;
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
      err_id_o    <= '0;
    end else begin
      miss_cnt_o <= cnt_next(miss_cnt_o, out_hs & is_miss, err_clr_i);
      mh_cnt_o   <= cnt_next(mh_cnt_o, out_hs & out_multi_hit_o, err_clr_i);
      prot_cnt_o <= cnt_next(prot_cnt_o, out_hs & out_prot_o, err_clr_i);
      if (out_hs && is_err && (!err_valid_o || err_clr_i)) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= out_addr_min_q;
        err_id_o    <= out_id_o;
      end else if (err_clr_i) begin
        err_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rab_slice_lookup_pipe.sv
// Directed bench for rab_slice_lookup_pipe: vector table plus hand-written
// backpressure, clear, saturation and reset sequences.
module tb_rab_slice_lookup_pipe;

  localparam int NS   = 16;
  localparam int NR   = 4 * NS;
  localparam int PHYS = 40;
  localparam int VIRT = 32;
  localparam int IDW  = 8;
  localparam int CW   = 16;
  localparam int NV   = 10;

  logic            clk;
  logic            rst_n;
  logic [63:0]     cfg [NR];
  logic            in_valid, in_rw, out_ready, err_clr;
  logic [VIRT-1:0] in_amin, in_amax;
  logic [IDW-1:0]  in_id;

  logic            in_ready, out_valid, out_master, out_hit, out_multi, out_prot, err_valid;
  logic [IDW-1:0]  out_id, err_id;
  logic [PHYS-1:0] out_addr;
  logic [3:0]      out_idx;
  logic [VIRT-1:0] err_addr;
  logic [CW-1:0]   miss_cnt, mh_cnt, prot_cnt;

  logic            in_ready1, out_valid1, out_master1, out_hit1, out_multi1, out_prot1, err_valid1;
  logic [IDW-1:0]  out_id1, err_id1;
  logic [PHYS-1:0] out_addr1;
  logic [3:0]      out_idx1;
  logic [VIRT-1:0] err_addr1;
  logic [CW-1:0]   miss_cnt1, mh_cnt1, prot_cnt1;

  rab_slice_lookup_pipe #(.N_SLICES(NS), .MH_POLICY(0)) dut0 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .cfg_regs_i(cfg),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_rw_i(in_rw),
    .in_addr_min_i(in_amin), .in_addr_max_i(in_amax), .in_id_i(in_id),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_id_o(out_id),
    .out_addr_o(out_addr), .out_master_sel_o(out_master), .out_hit_o(out_hit),
    .out_hit_idx_o(out_idx), .out_multi_hit_o(out_multi), .out_prot_o(out_prot),
    .err_clr_i(err_clr), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .err_id_o(err_id), .miss_cnt_o(miss_cnt), .mh_cnt_o(mh_cnt), .prot_cnt_o(prot_cnt)
  );

  rab_slice_lookup_pipe #(.N_SLICES(NS), .MH_POLICY(1)) dut1 (
    .Clk_CI(clk), .Rst_RBI(rst_n), .cfg_regs_i(cfg),
    .in_valid_i(in_valid), .in_ready_o(in_ready1), .in_rw_i(in_rw),
    .in_addr_min_i(in_amin), .in_addr_max_i(in_amax), .in_id_i(in_id),
    .out_valid_o(out_valid1), .out_ready_i(out_ready), .out_id_o(out_id1),
    .out_addr_o(out_addr1), .out_master_sel_o(out_master1), .out_hit_o(out_hit1),
    .out_hit_idx_o(out_idx1), .out_multi_hit_o(out_multi1), .out_prot_o(out_prot1),
    .err_clr_i(err_clr), .err_valid_o(err_valid1), .err_addr_o(err_addr1),
    .err_id_o(err_id1), .miss_cnt_o(miss_cnt1), .mh_cnt_o(mh_cnt1), .prot_cnt_o(prot_cnt1)
  );

  typedef struct {
    logic            rw;
    logic [VIRT-1:0] amin;
    logic [VIRT-1:0] amax;
    logic [IDW-1:0]  id;
    logic            hit;
    logic [3:0]      idx;
    logic [PHYS-1:0] addr;
    logic            master;
    logic            multi;
    logic            prot;
  } vec_t;

  vec_t vecs [NV];
  int   total = 0;
  int   bad   = 0;
  int   sent  = 0;
  int   hs_cnt = 0;
  int   hs0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && out_valid && out_ready) hs_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_slice(input int s, input logic [63:0] mn, input logic [63:0] mx,
                           input logic [63:0] offs, input logic [63:0] flags);
    cfg[4*s+0] = mn;
    cfg[4*s+1] = mx;
    cfg[4*s+2] = offs;
    cfg[4*s+3] = flags;
  endtask

  task automatic send(input logic rw, input logic [VIRT-1:0] amin,
                      input logic [VIRT-1:0] amax, input logic [IDW-1:0] id);
    bit done = 1'b0;
    in_rw = rw; in_amin = amin; in_amax = amax; in_id = id; in_valid = 1'b1;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) check("accept timeout", 64'(done), 64'd1);
    sent++;
  endtask

  task automatic wait_out(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) check({name, " out_valid timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic run_vec(input int i);
    send(vecs[i].rw, vecs[i].amin, vecs[i].amax, vecs[i].id);
    wait_out($sformatf("v%0d", i));
    check($sformatf("v%0d id", i), 64'(out_id), 64'(vecs[i].id));
    check($sformatf("v%0d hit", i), 64'(out_hit), 64'(vecs[i].hit));
    check($sformatf("v%0d idx", i), 64'(out_idx), 64'(vecs[i].idx));
    check($sformatf("v%0d addr", i), 64'(out_addr), 64'(vecs[i].addr));
    check($sformatf("v%0d master", i), 64'(out_master), 64'(vecs[i].master));
    check($sformatf("v%0d multi", i), 64'(out_multi), 64'(vecs[i].multi));
    check($sformatf("v%0d prot", i), 64'(out_prot), 64'(vecs[i].prot));
    if (vecs[i].multi) begin
      check($sformatf("v%0d p1 hit", i), 64'(out_hit1), 64'd1);
      check($sformatf("v%0d p1 idx", i), 64'(out_idx1), 64'd1);
      check($sformatf("v%0d p1 multi", i), 64'(out_multi1), 64'd1);
      check($sformatf("v%0d p1 addr", i), 64'(out_addr1), 64'h10_0000_0010);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rw    amin           amax           id     hit   idx   addr               mst   mh    prot
    vecs[0] = '{1'b0, 32'h0000_1100, 32'h0000_113F, 8'h05, 1'b1, 4'd2, 40'h80_0000_0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_1100, 32'h0000_113F, 8'h06, 1'b1, 4'd2, 40'h0,            1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_2010, 32'h0000_2010, 8'h07, 1'b0, 4'd0, 40'h0,            1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_1FF0, 32'h0000_200F, 8'h08, 1'b0, 4'd0, 40'h0,            1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h4000_0010, 32'h4000_001F, 8'h10, 1'b1, 4'd5, 40'h12_3400_0010, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h4000_0010, 32'h4000_001F, 8'h11, 1'b1, 4'd5, 40'h12_3400_0010, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_2000, 32'hFFFF_FFFF, 8'h12, 1'b1, 4'd6, 40'h00_0000_1000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_6000, 32'h0000_6010, 8'h13, 1'b0, 4'd0, 40'h0,            1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_1000, 32'h0000_1FFF, 8'h14, 1'b1, 4'd2, 40'h80_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 32'h0000_0FFF, 32'h0000_1000, 8'h15, 1'b0, 4'd0, 40'h0,            1'b0, 1'b0, 1'b0};

    for (int i = 0; i < NR; i++) cfg[i] = 64'h0;
    set_slice(2, 64'h1000, 64'h1FFF, 64'h80_0000_0000, 64'h3);
    set_slice(1, 64'h2000, 64'h2FFF, 64'h10_0000_0000, 64'hF);
    set_slice(3, 64'h2000, 64'h2FFF, 64'h30_0000_0000, 64'h7);
    set_slice(5, 64'h4000_0000, 64'h4FFF_FFFF, 64'h12_3400_0000, 64'hF);
    set_slice(6, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFF_FFFF_F000, 64'h3);
    set_slice(7, 64'h6000, 64'h6FFF, 64'h70_0000_0000, 64'h6);

    in_valid = 1'b0; in_rw = 1'b0; in_amin = '0; in_amax = '0; in_id = '0;
    out_ready = 1'b1; err_clr = 1'b0; rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_addr", 64'(out_addr), 64'd0);
    check("rst err_valid", 64'(err_valid), 64'd0);
    check("rst miss_cnt", 64'(miss_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    check("tbl prot_cnt", 64'(prot_cnt), 64'd1);
    check("tbl mh_cnt", 64'(mh_cnt), 64'd1);
    check("tbl miss_cnt", 64'(miss_cnt), 64'd3);
    check("tbl err_valid", 64'(err_valid), 64'd1);
    check("tbl err_addr", 64'(err_addr), 64'h1100);
    check("tbl err_id", 64'(err_id), 64'h06);
    check("tbl p1 mh_cnt", 64'(mh_cnt1), 64'd1);
    check("tbl p1 miss_cnt", 64'(miss_cnt1), 64'd3);

    // Clear coinciding with a miss handshake.
    send(1'b0, 32'h6000, 32'h6004, 8'h09);
    wait_out("clr+miss");
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr+miss err_valid", 64'(err_valid), 64'd1);
    check("clr+miss err_id", 64'(err_id), 64'h09);
    check("clr+miss err_addr", 64'(err_addr), 64'h6000);
    check("clr+miss miss_cnt", 64'(miss_cnt), 64'd1);
    check("clr+miss prot_cnt", 64'(prot_cnt), 64'd0);
    check("clr+miss mh_cnt", 64'(mh_cnt), 64'd0);

    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr err_valid", 64'(err_valid), 64'd0);
    check("clr miss_cnt", 64'(miss_cnt), 64'd0);

    // Straddling burst, then saturate the miss counter with a full-rate stream.
    send(1'b0, 32'h1FF0, 32'h200F, 8'h30);
    wait_out("straddle");
    check("straddle hit", 64'(out_hit), 64'd0);
    @(posedge clk);
    #1;
    check("straddle miss_cnt", 64'(miss_cnt), 64'd1);
    check("straddle err_id", 64'(err_id), 64'h30);

    hs0 = hs_cnt;
    in_rw = 1'b0; in_amin = 32'h0000_0100; in_amax = 32'h0000_0100; in_id = 8'h31;
    in_valid = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream handshakes", 64'(hs_cnt - hs0), 64'd65536);
    check("sat miss_cnt", 64'(miss_cnt), 64'hFFFF);
    check("stream drained", 64'(out_valid), 64'd0);

    // Backpressure: four back-to-back requests, consumer stalled for 3 cycles.
    sent = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send(1'b0, 32'h1000 + 32'(k * 64), 32'h103F + 32'(k * 64), 8'(8'h20 + k));
      end
      begin
        int got = 0;
        repeat (2) @(posedge clk);
        #1;
        check("bp out_valid", 64'(out_valid), 64'd1);
        check("bp in_ready low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("bp held id", 64'(out_id), 64'h20);
        check("bp held addr", 64'(out_addr), 64'h80_0000_0000);
        check("bp still stalled", 64'(in_ready), 64'd0);
        check("bp accepted", 64'(sent), 64'd2);
        out_ready = 1'b1;
        for (int n = 0; n < 40 && got < 4; n++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            check($sformatf("bp id%0d", got), 64'(out_id), 64'(8'h20 + got));
            check($sformatf("bp addr%0d", got), 64'(out_addr), 64'h80_0000_0000 + 64'(got * 64));
            got++;
          end
        end
        check("bp delivered", 64'(got), 64'd4);
      end
    join
    @(posedge clk);
    #1;

    // Reset with two requests in flight.
    out_ready = 1'b0;
    send(1'b0, 32'h1100, 32'h1100, 8'h40);
    send(1'b0, 32'h1140, 32'h1140, 8'h41);
    check("inflight out_valid", 64'(out_valid), 64'd1);
    hs0 = hs_cnt;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 64'(out_valid), 64'd0);
    check("mid-rst miss_cnt", 64'(miss_cnt), 64'd0);
    check("mid-rst err_valid", 64'(err_valid), 64'd0);
    check("mid-rst out_id", 64'(out_id), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post-rst no handshake", 64'(hs_cnt - hs0), 64'd0);
    check("post-rst out_valid", 64'(out_valid), 64'd0);
    check("post-rst ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
